// File: rtl/floating_point_multichannel_accumulator_if.sv
// Sample and result bus of the multi-channel floating point accumulator.
// Defining FPACC_STATUS_EN adds the overflowOut status line.
interface floating_point_multichannel_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_WIDTH = 2
);
  logic                  validIn;
  logic                  lastIn;
  logic [CHAN_WIDTH-1:0] chanIn;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  validOut;
  logic [CHAN_WIDTH-1:0] chanOut;
  logic [DATA_WIDTH-1:0] dataOut;
`ifdef FPACC_STATUS_EN
  logic                  overflowOut;

  modport master (output validIn, lastIn, chanIn, dataIn,
                  input  validOut, chanOut, dataOut, overflowOut);
  modport slave  (input  validIn, lastIn, chanIn, dataIn,
                  output validOut, chanOut, dataOut, overflowOut);
`else
  modport master (output validIn, lastIn, chanIn, dataIn,
                  input  validOut, chanOut, dataOut);
  modport slave  (input  validIn, lastIn, chanIn, dataIn,
                  output validOut, chanOut, dataOut);
`endif
endinterface

// File: rtl/floating_point_multichannel_accumulator.sv
// NUM_CHAN independent FP running sums sharing one combinational RNE adder; lastIn emits the sum
// one cycle later. FPACC_STATUS_EN adds a sticky per-channel overflow bit on overflowOut.
module floating_point_multichannel_accumulator #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 24,
  parameter int NUM_CHAN   = 4
) (
  input logic clkIn,
  input logic rstIn,
  floating_point_multichannel_accumulator_if.slave bus
);
  localparam int DATA_WIDTH = EXP_WIDTH + FRAC_WIDTH;
  localparam int CHAN_WIDTH = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam int MW = FRAC_WIDTH - 1;
  localparam int AW = FRAC_WIDTH + 3;
  localparam int SW = EXP_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0]  EMAX   = '1;
  localparam logic [EXP_WIDTH-1:0]  LP_AW  = EXP_WIDTH'(AW);
  localparam logic [CHAN_WIDTH:0]   LP_NCH = (CHAN_WIDTH+1)'(NUM_CHAN);
  localparam logic [DATA_WIDTH-1:0] QNAN   = {1'b0, EMAX, 1'b1, {(MW-1){1'b0}}};

  logic [DATA_WIDTH-1:0] r_sum [NUM_CHAN];
  logic [NUM_CHAN-1:0]   r_busy;
  logic                  r_vld;
  logic [CHAN_WIDTH-1:0] r_chan;
  logic [DATA_WIDTH-1:0] r_dat;

  logic                  w_chan_ok, w_acc;
  logic [CHAN_WIDTH-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_add, w_new;
  logic                  w_sa, w_sb, w_zero_a, w_zero_b, w_spec_a, w_spec_b, w_nan_a, w_nan_b;
  logic [EXP_WIDTH-1:0]  w_ea, w_eb, w_exp_l, w_exp_s, w_dexp, w_shamt;
  logic [MW-1:0]         w_ma, w_mb, w_man_r;
  logic                  w_swap, w_sgn_l, w_stk, w_rup;
  logic [AW-1:0]         w_man_l, w_man_s, w_shr, w_al, w_norm;
  logic [AW:0]           w_sum;
  logic [SW-1:0]         w_lz, w_exp_n, w_exp_r;
  logic [FRAC_WIDTH:0]   w_rnd;

  assign w_chan_ok = ({1'b0, bus.chanIn} < LP_NCH);
  assign w_acc     = bus.validIn & w_chan_ok;
  assign w_idx     = w_chan_ok ? bus.chanIn : '0;
  assign w_a       = r_sum[w_idx];
  assign w_b       = bus.dataIn;

  assign w_sa     = w_a[DATA_WIDTH-1];
  assign w_sb     = w_b[DATA_WIDTH-1];
  assign w_ea     = w_a[DATA_WIDTH-2 -: EXP_WIDTH];
  assign w_eb     = w_b[DATA_WIDTH-2 -: EXP_WIDTH];
  assign w_ma     = w_a[MW-1:0];
  assign w_mb     = w_b[MW-1:0];
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  assign w_spec_a = (w_ea == EMAX);
  assign w_spec_b = (w_eb == EMAX);
  assign w_nan_a  = w_spec_a & (w_ma != '0);
  assign w_nan_b  = w_spec_b & (w_mb != '0);
  assign w_swap   = ({w_eb, w_mb} > {w_ea, w_ma});

  always_comb begin
    w_sgn_l = w_swap ? w_sb : w_sa;
    w_exp_l = w_swap ? w_eb : w_ea;
    w_exp_s = w_swap ? w_ea : w_eb;
    w_man_l = w_swap ? {1'b1, w_mb, 3'b000} : {1'b1, w_ma, 3'b000};
    w_man_s = w_swap ? {1'b1, w_ma, 3'b000} : {1'b1, w_mb, 3'b000};
    w_dexp  = w_exp_l - w_exp_s;
    w_shamt = (w_dexp > LP_AW) ? LP_AW : w_dexp;
    w_shr   = w_man_s >> w_shamt;
    w_stk   = |(w_man_s & ~({AW{1'b1}} << w_shamt));
    // Shifted-out bits collapse into the bottom (sticky) position.
    w_al    = {w_shr[AW-1:1], w_shr[0] | w_stk};
    w_sum   = (w_sa == w_sb) ? ({1'b0, w_man_l} + {1'b0, w_al})
                             : ({1'b0, w_man_l} - {1'b0, w_al});
    w_lz = '0;
    for (int i = 0; i < AW; i++) begin
      if (w_sum[i]) w_lz = SW'(AW - 1 - i);
    end
    if (w_sum[AW]) begin
      w_norm  = {w_sum[AW:2], w_sum[1] | w_sum[0]};
      w_exp_n = {2'b00, w_exp_l} + SW'(1);
    end else begin
      w_norm  = w_sum[AW-1:0] << w_lz;
      w_exp_n = {2'b00, w_exp_l} - w_lz;
    end
    w_rup   = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_rnd   = {1'b0, w_norm[AW-1:3]} + {{FRAC_WIDTH{1'b0}}, w_rup};
    w_exp_r = w_exp_n + {{(SW-1){1'b0}}, w_rnd[FRAC_WIDTH]};
    w_man_r = w_rnd[FRAC_WIDTH] ? w_rnd[MW:1] : w_rnd[MW-1:0];

    w_add = {w_sgn_l, w_exp_r[EXP_WIDTH-1:0], w_man_r};
    if (w_sum == '0 || w_exp_r[SW-1] || w_exp_r == '0)
      w_add = '0;
    else if (w_exp_r[SW-2:0] >= {1'b0, EMAX})
      w_add = {w_sgn_l, EMAX, {MW{1'b0}}};
    // Specials and flushed-zero operands override the arithmetic path.
    if (w_nan_a | w_nan_b | (w_spec_a & w_spec_b & (w_sa != w_sb)))
      w_add = QNAN;
    else if (w_spec_a)
      w_add = w_a;
    else if (w_spec_b)
      w_add = w_b;
    else if (w_zero_a & w_zero_b)
      w_add = {w_sa & w_sb, {(DATA_WIDTH-1){1'b0}}};
    else if (w_zero_a)
      w_add = w_b;
    else if (w_zero_b)
      w_add = w_a;
  end

  assign w_new = r_busy[w_idx] ? w_add : w_b;

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_CHAN; i++) r_sum[i] <= '0;
      r_vld  <= 1'b0;
      r_chan <= '0;
      r_dat  <= '0;
    end else begin
      r_vld <= w_acc & bus.lastIn;
      if (w_acc) begin
        r_sum[w_idx]  <= w_new;
        r_busy[w_idx] <= ~bus.lastIn;
        if (bus.lastIn) begin
          r_chan <= w_idx;
          r_dat  <= w_new;
        end
      end
    end
  end

  assign bus.validOut = r_vld;
  assign bus.chanOut  = r_chan;
  assign bus.dataOut  = r_dat;

`ifdef FPACC_STATUS_EN
  logic [NUM_CHAN-1:0] r_ovf;
  logic                r_ovf_out;
  logic                w_ovf, w_ovf_run;

  // From finite operands the only all-ones-exponent result is an overflow to infinity.
  assign w_ovf     = ~w_spec_a & ~w_spec_b & (w_add[DATA_WIDTH-2 -: EXP_WIDTH] == EMAX);
  assign w_ovf_run = r_ovf[w_idx] | (r_busy[w_idx] & w_ovf);

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_ovf     <= '0;
      r_ovf_out <= 1'b0;
    end else if (w_acc) begin
      r_ovf[w_idx] <= ~bus.lastIn & w_ovf_run;
      if (bus.lastIn) r_ovf_out <= w_ovf_run;
    end
  end

  assign bus.overflowOut = r_ovf_out;
`endif
endmodule

// File: tb/tb_floating_point_multichannel_accumulator.sv
// Scoreboard bench: stimulus pushes expected sums (real-arithmetic reference model) into a queue;
// a negedge monitor pops and compares every emitted sum, its channel and its latency.
module tb_floating_point_multichannel_accumulator;
  localparam int NCH = 4;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef struct {
    logic [1:0]  chan;
    logic [31:0] dat;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_q = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_pushed = 0;
  int          n_seen = 0;
  exp_t        sb[$];
  logic [31:0] m_sum [NCH];
  bit          m_busy [NCH];
  bit          m_ovf [NCH];
  int          rem [NCH];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  floating_point_multichannel_accumulator_if #(.DATA_WIDTH(32), .CHAN_WIDTH(2)) bus ();

  floating_point_multichannel_accumulator #(
    .EXP_WIDTH(8), .FRAC_WIDTH(24), .NUM_CHAN(NCH)
  ) dut (
    .clkIn(clk),
    .rstIn(rst),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Subnormals read as zero; normals widen exactly into a double.
  function automatic real to_real(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'd0});
  endfunction

  // Round a double to binary32 (RNE); overflow -> signed inf, below min normal -> +0.
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    int          e;
    logic [24:0] m;
    bit          up;
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 896;
    up = d[28] && ((|d[27:0]) || d[29]);
    m  = {2'b01, d[51:29]} + 25'(up);
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return 32'd0;
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    real s;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && a[31] != b[31])) return QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    s = to_real(a) + to_real(b);
    if (s == 0.0)
      return (to_real(a) == 0.0 && to_real(b) == 0.0 && a[31] && b[31]) ? 32'h80000000 : 32'h0;
    return to_f32(s);
  endfunction

  task automatic issue(input int c, input logic [31:0] d, input bit last,
                       input bit use_want = 1'b0, input logic [31:0] want = 32'h0);
    exp_t        e;
    logic [31:0] r;
    @(negedge clk);
    bus.validIn = 1'b1;
    bus.lastIn  = last;
    bus.chanIn  = 2'(c);
    bus.dataIn  = d;
    if (!m_busy[c]) r = d;
    else begin
      r = model_add(m_sum[c], d);
      if (!is_nan(m_sum[c]) && !is_inf(m_sum[c]) && !is_nan(d) && !is_inf(d) && r[30:23] == 8'hFF)
        m_ovf[c] = 1'b1;
    end
    m_sum[c]  = r;
    m_busy[c] = !last;
    if (last) begin
      e.chan = 2'(c);
      e.dat  = use_want ? want : r;
      e.ovf  = m_ovf[c];
      e.cyc  = cyc;
      sb.push_back(e);
      n_pushed++;
      m_ovf[c] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.validIn = 1'b0;
      bus.lastIn  = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.validIn = 1'b0;
    bus.lastIn  = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 1'b0;
      m_ovf[c]  = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(112, 140)), 23'($urandom)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_q) chk("valid_low_in_reset", 32'(bus.validOut), 32'd0);
    else if (bus.validOut === 1'b1) begin
      n_seen++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sum_data", bus.dataOut, e.dat);
        chk("sum_chan", 32'(bus.chanOut), 32'(e.chan));
        chk("sum_latency", cyc, e.cyc + 1);
`ifdef FPACC_STATUS_EN
        chk("overflow_flag", 32'(bus.overflowOut), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin
    int c;
    bus.validIn = 1'b0;
    bus.lastIn  = 1'b0;
    bus.chanIn  = 2'd0;
    bus.dataIn  = 32'd0;
    for (int i = 0; i < NCH; i++) begin
      m_busy[i] = 1'b0;
      m_ovf[i]  = 1'b0;
      m_sum[i]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_dataOut", bus.dataOut, 32'd0);
    chk("reset_chanOut", 32'(bus.chanOut), 32'd0);
`ifdef FPACC_STATUS_EN
    chk("reset_overflowOut", 32'(bus.overflowOut), 32'd0);
`endif
    rst = 1'b0;
    idle(2);

    issue(0, 32'h3F800000, 0);
    issue(0, 32'h40000000, 0);
    issue(0, 32'h40400000, 0);
    issue(0, 32'h40800000, 1, 1, 32'h41200000);
    idle(3);
    issue(2, 32'h3F800000, 1, 1, 32'h3F800000);
    idle(3);
    issue(0, 32'h3F800000, 0);
    issue(1, 32'h3F000000, 0);
    issue(0, 32'h40000000, 1, 1, 32'h40400000);
    issue(1, 32'h3E800000, 1, 1, 32'h3F400000);
    idle(3);
    issue(1, 32'h3F800000, 0);
    issue(1, 32'h33800000, 1, 1, 32'h3F800000);
    issue(1, 32'h3F800000, 0);
    issue(1, 32'hBF800000, 1, 1, 32'h00000000);
    idle(3);
    issue(3, 32'h7F7FFFFF, 0);
    issue(3, 32'h7F7FFFFF, 1, 1, 32'h7F800000);
    issue(3, 32'h3F800000, 1, 1, 32'h3F800000);
    issue(2, 32'h7F800000, 0);
    issue(2, 32'hFF800000, 1, 1, QNAN);
    issue(2, 32'h00000001, 0);
    issue(2, 32'h3F800000, 1, 1, 32'h3F800000);
    idle(3);
    issue(0, 32'h3F800000, 0);
    issue(0, 32'h40000000, 0);
    pulse_reset();
    issue(0, 32'h40A00000, 1, 1, 32'h40A00000);
    idle(3);

    for (int round = 0; round < 3; round++) begin
      for (int k = 0; k < NCH; k++) rem[k] = $urandom_range(1, 256);
      if (round == 0) begin
        rem[0] = 1;
        rem[1] = 256;
      end
      while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
        c = $urandom_range(0, NCH - 1);
        while (rem[c] == 0) c = (c + 1) % NCH;
        if ($urandom_range(0, 7) == 0) idle(1);
        issue(c, rand_fp(), rem[c] == 1);
        rem[c]--;
      end
      idle(2);
    end

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    idle(4);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("output_count", 32'(n_seen), 32'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
